// File: rtl/datapath_seq_mult.sv
// Byte-serial operand loader, iterative shift-add multiplier (unsigned/signed)
// and paged 7-segment product display for the board switch/button front panel.
module datapath_seq_mult #(
    parameter  int WIDTH  = 32,
    localparam int PAGES  = (2 * WIDTH + 15) / 16,
    localparam int PSEL_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic [7:0]        inputdata,
    input  logic              loaddata,
    input  logic              signed_mode,
    input  logic [PSEL_W-1:0] page_sel,
    output logic              inputdata_ready,
    output logic              busy,
    output logic              done,
    output logic [6:0]        disp3,
    output logic [6:0]        disp2,
    output logic [6:0]        disp1,
    output logic [6:0]        disp0
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = 4;
    localparam int ITER_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] MULT   = 3'd3;
    localparam logic [2:0] FIX    = 3'd4;
    localparam logic [2:0] SHOW   = 3'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic               enter_q;
    logic [CNT_W-1:0]   byte_cnt;
    logic [ITER_W-1:0]  iter;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   b_next;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic               neg;
    logic               accept;
    logic               last_byte;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
        mag = (sm && v[WIDTH-1]) ? -v : v;
    endfunction

    // Handshake: while inputdata_ready is high, each rising edge of enter is one
    // transfer of inputdata; edges seen while inputdata_ready is low are dropped.
    assign accept    = enter & ~enter_q;
    assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));
    assign a_next    = (a_reg << 8) | WIDTH'(inputdata);
    assign b_next    = (b_reg << 8) | WIDTH'(inputdata);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (loaddata) state_next = LOAD_A;
            LOAD_A:  if (accept && last_byte) state_next = LOAD_B;
            LOAD_B:  if (accept && last_byte) state_next = MULT;
            MULT:    if (iter == ITER_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = SHOW;
            SHOW:    if (loaddata) state_next = LOAD_A;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            enter_q         <= 1'b0;
            byte_cnt        <= '0;
            iter            <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            mplier          <= '0;
            mcand_sh        <= '0;
            acc             <= '0;
            product         <= '0;
            neg             <= 1'b0;
            inputdata_ready <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_next;
            enter_q         <= enter;
            inputdata_ready <= (state_next == LOAD_A) || (state_next == LOAD_B);
            busy            <= (state_next == MULT) || (state_next == FIX);
            done            <= (state_next == SHOW);
            case (state)
                IDLE, SHOW: begin
                    if (loaddata) begin
                        a_reg    <= '0;
                        b_reg    <= '0;
                        byte_cnt <= '0;
                        product  <= '0;
                    end
                end
                LOAD_A: begin
                    if (accept) begin
                        a_reg    <= a_next;
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        b_reg    <= b_next;
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                        if (last_byte) begin
                            // b_next is the completed operand; magnitudes are formed here so
                            // MULT spends exactly WIDTH cycles on shift-add.
                            mcand_sh <= (2*WIDTH)'(mag(a_reg, signed_mode));
                            mplier   <= mag(b_next, signed_mode);
                            neg      <= signed_mode & (a_reg[WIDTH-1] ^ b_next[WIDTH-1]);
                            acc      <= '0;
                            iter     <= '0;
                        end
                    end
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + mcand_sh;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    iter     <= iter + 1'b1;
                end
                FIX: begin
                    product <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

    logic [16*PAGES-1:0] prod_ext;
    logic [15:0]         page_word;
    logic                page_ok;

    assign prod_ext = (16*PAGES)'(product);

    always_comb begin
        page_word = '0;
        page_ok   = 1'b0;
        for (int p = 0; p < PAGES; p++) begin
            if (page_sel == PSEL_W'(p)) begin
                page_ok   = 1'b1;
                page_word = prod_ext[16*p +: 16];
            end
        end
    end

    always_comb begin
        disp3 = SEG_BLANK;
        disp2 = SEG_BLANK;
        disp1 = SEG_BLANK;
        disp0 = SEG_BLANK;
        case (state)
            LOAD_A, LOAD_B: begin
                disp3 = (state == LOAD_A) ? 7'h08 : 7'h03;
                disp2 = hex7(4'(NBYTES - int'(byte_cnt)));
                disp1 = hex7(inputdata[7:4]);
                disp0 = hex7(inputdata[3:0]);
            end
            MULT, FIX: begin
                disp3 = SEG_DASH;
                disp2 = SEG_DASH;
                disp1 = SEG_DASH;
                disp0 = SEG_DASH;
            end
            SHOW: begin
                if (page_ok) begin
                    disp3 = hex7(page_word[15:12]);
                    disp2 = hex7(page_word[11:8]);
                    disp1 = hex7(page_word[7:4]);
                    disp0 = hex7(page_word[3:0]);
                end else begin
                    disp3 = SEG_DASH;
                    disp2 = SEG_DASH;
                    disp1 = SEG_DASH;
                    disp0 = SEG_DASH;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_seq_mult.sv
// Directed bench for datapath_seq_mult: a 32-bit and a 24-bit instance share the
// panel inputs; each only leaves IDLE/SHOW on its own loaddata.
module tb_datapath_seq_mult;

    logic       clk;
    logic       reset;
    logic       enter;
    logic [7:0] inputdata;
    logic       loaddata32;
    logic       loaddata24;
    logic       signed_mode;
    logic [1:0] page_sel;

    logic       ready32, busy32, done32;
    logic [6:0] d3_32, d2_32, d1_32, d0_32;
    logic       ready24, busy24, done24;
    logic [6:0] d3_24, d2_24, d1_24, d0_24;

    int checks   = 0;
    int failures = 0;

    datapath_seq_mult #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata32), .signed_mode(signed_mode), .page_sel(page_sel),
        .inputdata_ready(ready32), .busy(busy32), .done(done32),
        .disp3(d3_32), .disp2(d2_32), .disp1(d1_32), .disp0(d0_32)
    );

    datapath_seq_mult #(.WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
        .loaddata(loaddata24), .signed_mode(signed_mode), .page_sel(page_sel),
        .inputdata_ready(ready24), .busy(busy24), .done(done24),
        .disp3(d3_24), .disp2(d2_24), .disp1(d1_24), .disp0(d0_24)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] page_segs(input logic [15:0] w);
        page_segs = {seg(w[15:12]), seg(w[11:8]), seg(w[7:4]), seg(w[3:0])};
    endfunction

    function automatic logic [27:0] disp_of(input int which);
        disp_of = (which != 0) ? {d3_24, d2_24, d1_24, d0_24} : {d3_32, d2_32, d1_32, d0_32};
    endfunction

    function automatic logic [2:0] flags_of(input int which);
        flags_of = (which != 0) ? {ready24, busy24, done24} : {ready32, busy32, done32};
    endfunction

    // driver tasks
    task automatic press(input logic [7:0] v);
        inputdata = v;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_chk(input int which, input int nb);
        if (which != 0) loaddata24 = 1'b1; else loaddata32 = 1'b1;
        @(negedge clk);
        loaddata24 = 1'b0;
        loaddata32 = 1'b0;
        check("start_flags", flags_of(which), 3'b100);
        check("start_disp", disp_of(which),
              {7'h08, seg(4'(nb)), seg(inputdata[7:4]), seg(inputdata[3:0])});
    endtask

    // Final B byte, then count edges to done; poke pulses enter mid-MULT,
    // abort asserts reset mid-MULT and returns.
    task automatic finish_b(input int which, input logic [7:0] v, input logic sm,
                            input int nb, input int poke, input int abort);
        int   n;
        logic got;
        n = 0;
        got = 1'b0;
        inputdata = v;
        signed_mode = sm;
        enter = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
        signed_mode = 1'b0;
        check("mult_flags", flags_of(which), 3'b010);
        while (!got && n < 300) begin
            @(posedge clk);
            n++;
            #1;
            enter = 1'b0;
            if (n == poke) enter = 1'b1;
            if (n == abort) begin
                reset = 1'b0;
                #1;
                check("abort_flags", flags_of(which), 3'b000);
                check("abort_disp", disp_of(which), {4{7'h7F}});
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end
            got = flags_of(which) == 3'b001;
        end
        check("latency", n, nb * 8 + 1);
        check("show_flags", flags_of(which), 3'b001);
        @(negedge clk);
    endtask

    task automatic run_mult(input int which, input logic [63:0] a, input logic [63:0] b,
                            input int nb, input logic sm, input int poke, input int abort);
        start_chk(which, nb);
        for (int i = nb - 1; i >= 0; i--) press(a[8*i +: 8]);
        check("ab_disp", disp_of(which), {7'h03, seg(4'(nb)), seg(a[7:4]), seg(a[3:0])});
        for (int i = nb - 1; i >= 1; i--) press(b[8*i +: 8]);
        finish_b(which, b[7:0], sm, nb, poke, abort);
    endtask

    task automatic check_pages(input int which, input logic [63:0] exp, input int np);
        logic [15:0] w;
        for (int p = 0; p < np; p++) begin
            page_sel = 2'(p);
            #1;
            w = exp[16*p +: 16];
            check($sformatf("page%0d", p), disp_of(which), page_segs(w));
        end
        page_sel = 2'd0;
    endtask

    initial begin
        reset = 1'b0;
        enter = 1'b0;
        inputdata = 8'h00;
        loaddata32 = 1'b0;
        loaddata24 = 1'b0;
        signed_mode = 1'b0;
        page_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_flags32", flags_of(0), 3'b000);
        check("rst_disp32", disp_of(0), {4{7'h7F}});
        check("rst_flags24", flags_of(1), 3'b000);
        reset = 1'b1;
        @(negedge clk);

        // enter ignored in IDLE
        press(8'h55);
        press(8'hAA);
        check("idle_flags", flags_of(0), 3'b000);
        check("idle_disp", disp_of(0), {4{7'h7F}});

        // held enter gives one accept; then 3 x 5
        start_chk(0, 4);
        inputdata = 8'h00;
        enter = 1'b1;
        repeat (20) @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        check("held_disp", disp_of(0), {7'h08, seg(4'h3), seg(4'h0), seg(4'h0)});
        press(8'h00);
        press(8'h00);
        press(8'h03);
        check("held_b_disp", disp_of(0), {7'h03, seg(4'h4), seg(4'h0), seg(4'h3)});
        press(8'h00);
        press(8'h00);
        press(8'h00);
        finish_b(0, 8'h05, 1'b0, 4, 0, 0);
        check_pages(0, 64'h0000_0000_0000_000F, 4);

        // enter pulse in MULT is ignored
        run_mult(0, 64'hFFFF_FFFE, 64'h0000_0003, 4, 1'b1, 5, 0);
        check_pages(0, 64'hFFFF_FFFF_FFFF_FFFA, 4);
        run_mult(0, 64'hFFFF_FFFE, 64'h0000_0003, 4, 1'b0, 0, 0);
        check_pages(0, 64'h0000_0002_FFFF_FFFA, 4);
        run_mult(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4, 1'b0, 0, 0);
        check_pages(0, 64'hFFFF_FFFE_0000_0001, 4);
        run_mult(0, 64'h8000_0000, 64'h8000_0000, 4, 1'b1, 0, 0);
        check_pages(0, 64'h4000_0000_0000_0000, 4);

        // reset mid-MULT, then a clean signed -1 x 7
        run_mult(0, 64'h0000_0012, 64'h0000_0034, 4, 1'b0, 0, 10);
        check("post_rst_flags", flags_of(0), 3'b000);
        run_mult(0, 64'hFFFF_FFFF, 64'h0000_0007, 4, 1'b1, 0, 0);
        check_pages(0, 64'hFFFF_FFFF_FFFF_FFF9, 4);

        // 24-bit instance
        run_mult(1, 64'hFF_FFFF, 64'hFF_FFFF, 3, 1'b0, 0, 0);
        check_pages(1, 64'h0000_FFFF_FE00_0001, 3);
        page_sel = 2'd3;
        #1;
        check("page3_dash24", disp_of(1), {4{7'h3F}});
        page_sel = 2'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_seq_mult.md
Name: datapath_seq_mult

Overview:
- Parametrised, fully sequential successor to the combinational multiply datapath.
- Loads two WIDTH-bit operands byte-serially from the 8-bit switch bus, one byte per enter press.
- Multiplies them with an iterative shift-add engine in unsigned or signed mode.
- Shows the 2*WIDTH-bit product one 16-bit page at a time on four 7-segment digits. It sits between the board switches/buttons and the display pins.

Parameters:
- WIDTH, 32, operand width in bits; multiple of 8, range 8..64.
- PAGES, 2*WIDTH/16 rounded up, number of 16-bit product pages (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enter  in  1  load button, level, already synchronised; block edge-detects it.
- inputdata  in  8  switch byte.
- loaddata  in  1  start a new load sequence (level, sampled each cycle).
- signed_mode  in  1  1 = two's-complement multiply; sampled on the final B-byte capture edge.
- page_sel  in  $clog2(PAGES)  product page shown in SHOW; page 0 = bits [15:0].
- inputdata_ready  out  1  block is waiting for an operand byte.
- busy  out  1  multiply in progress.
- done  out  1  product valid and displayed.
- disp3, disp2, disp1, disp0  out  7 each  segments {g,f,e,d,c,b,a}, active-low; disp3 is the leftmost digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; A, B, product, byte counter and enter_q cleared.
  - inputdata_ready=0, busy=0, done=0.
  - All displays blank (7'h7F).
- Enter edge: an accept occurs on a clock edge where enter=1 and enter_q=0. enter_q <= enter every cycle. A held enter yields exactly one accept.
- FSM states: IDLE, LOAD_A, LOAD_B, MULT, FIX, SHOW.
  - IDLE: loaddata=1 -> LOAD_A, clears A, B and the byte counter.
  - LOAD_A, on each accept: A <= {A[WIDTH-9:0], inputdata} (MSB byte first); counter++. On the accept that delivers byte WIDTH/8 -> LOAD_B, counter cleared.
  - LOAD_B: same as LOAD_A into B. The final accept latches signed_mode and goes to MULT.
  - MULT:
    - On entry, load magnitudes: if signed, |A| and |B|, and sign = A[W-1]^B[W-1].
    - Radix-2 shift-add over exactly WIDTH cycles, with a 2*WIDTH-bit accumulator.
  - FIX: 1 cycle. If signed and sign=1, product <= -accumulator; else product <= accumulator. Always present, so latency is constant.
  - SHOW: done=1. loaddata=1 -> LOAD_A, clears A, B, counter and product; done drops on the next edge.
- Latency: done rises on the clock edge WIDTH+1 edges after the final B-byte accept edge.
- Outputs by state:
  - inputdata_ready=1 only in LOAD_A/LOAD_B.
  - busy=1 only in MULT/FIX.
  - done=1 only in SHOW. All three are registered.
- Display:
  - IDLE: all blank.
  - LOAD_A/LOAD_B:
    - disp3 shows 'A' or 'b'.
    - disp2 shows the hex count of bytes still needed (WIDTH/8 - counter).
    - disp1/disp0 show the live inputdata hex.
  - MULT/FIX: all four digits show dash (7'h3F).
  - SHOW: hex of product[16*page_sel+15 : 16*page_sel]. page_sel >= PAGES shows four dashes. Bits beyond 2*WIDTH read as 0. page_sel changes take effect combinationally.
  - Hex glyphs: standard 0-9, A, b, C, d, E, F.
- Ignored inputs:
  - enter is ignored in IDLE, MULT, FIX and SHOW.
  - loaddata is ignored in LOAD_A, LOAD_B, MULT and FIX.
  - An accept and loaddata in the same LOAD cycle: the byte is taken, loaddata is dropped.
- Signed corner: most-negative × most-negative gives +2^(2W-2), which is representable; no overflow flag is needed.
- Reset mid-operation (any state): immediate return to reset values. A partially loaded operand is discarded.

Test Plan:
- WIDTH=32, unsigned. loaddata; bytes 00 00 00 03, then 00 00 00 05 -> done exactly 33 edges after the last accept. page 0 shows "000F"; pages 1-3 show "0000".
- Signed: A=FFFFFFFE, B=00000003 -> product FFFFFFFFFFFFFFFA; pages 3..0 show "FFFF FFFF FFFF FFFA". Same operands unsigned -> 00000002FFFFFFFA.
- Max values: A=B=FFFFFFFF unsigned -> pages "FFFF FFFE 0000 0001". Signed A=B=80000000 -> "4000 0000 0000 0000".
- Enter handling: enter held high for 20 cycles in LOAD_A -> counter advances by 1 and disp2 goes 4 -> 3. Enter pulses while in IDLE or MULT -> no state change.
- Reset timing: assert reset=0 mid-MULT (cycle 10) -> same cycle busy=0 and displays 7'h7F. After release, loaddata then a full load yields the correct product.
- WIDTH=24 instance: 3-byte operands, PAGES=3. FFFFFF × FFFFFF unsigned -> "FFFF FE00 0001". page_sel=3 shows four dashes.
